multicycle_control_fsm: RTL and testbench



---
 rtl/multicycle_control_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control FSM with a bounded memory-ready wait and a sticky trap.
// Define MCU_JAL_EN to add the JAL state (encoding 11); otherwise opcode 1101111 is illegal.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state
);

    localparam int              CW        = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MCU_JAL_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_WB_MEM    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_WB_ALU    = 4'd9,
        S_BRANCH    = 4'd10,
`ifdef MCU_JAL_EN
        S_JAL       = 4'd11,
`endif
        S_TRAP      = 4'd15
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [6:0]    op_q;
    logic [1:0]    cause_q, cause_d;
    logic          in_mem;
    logic          timeout;

    assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timeout = in_mem && !mem_ready && (wait_q == WAIT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            op_q    <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
`ifdef MCU_JAL_EN
                    OP_JAL:            state_d = S_JAL;
`endif
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_WB_MEM;
            S_WB_MEM:    state_d = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:    state_d = S_WB_ALU;
            S_WB_ALU:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
`ifdef MCU_JAL_EN
            S_JAL:       state_d = S_FETCH;
`endif
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
        end

        // Counts only while stalling in the same memory state; any entry, exit or ready clears it.
        wait_d = (in_mem && !mem_ready && (state_d == state_q)) ? wait_q + CW'(1) : '0;
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:    ALUSrcB = 2'b11;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b11;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b11;
                ALUOp   = 2'b10;
            end
            S_WB_ALU:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
`ifdef MCU_JAL_EN
            S_JAL: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                PCWrite  = 1'b1;
                PCSource = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each scenario plans per-cycle expected states,
// pushes the expected control vector as stimulus is driven and pops it when outputs are sampled.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MADDR = 4'd3, MREAD = 4'd4;
    localparam logic [3:0] WBMEM = 4'd5, MWRITE = 4'd6, EXR = 4'd7, EXI = 4'd8, WBALU = 4'd9;
    localparam logic [3:0] BR = 4'd10, JAL = 4'd11, TRAP = 4'd15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite;
    logic [1:0] MemtoReg, ALUOp, ALUSrcB, trap_cause;
    logic       ALUSrcA, RegWrite, trap;
    logic [3:0] state;

    multicycle_control_fsm #(.MEM_WAIT_MAX(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    wire [21:0] obs = {PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite,
                       MemtoReg, ALUOp, ALUSrcA, ALUSrcB, RegWrite, trap, trap_cause, state};

    typedef struct {
        logic [21:0] v;
        string       tag;
    } exp_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [6:0] op;
    } step_t;

    exp_t       sb[$];
    step_t      plan[$];
    exp_t       e;
    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_cause = 2'b00;

    // Expected output vector straight from the per-state control table.
    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr, input logic [1:0] cause);
        logic       pcw, pcwc, pcs, iord, irw, mrd, mwr, alua, rw, trp;
        logic [1:0] m2r, aop, alub;
        {pcw, pcwc, pcs, iord, irw, mrd, mwr, alua, rw, trp} = '0;
        {m2r, aop, alub} = '0;
        case (st)
            FETCH:  begin mrd = 1; alub = 2'b01; irw = mr; pcw = mr; end
            DECODE: alub = 2'b11;
            MADDR:  begin alua = 1; alub = 2'b11; end
            MREAD:  begin mrd = 1; iord = 1; end
            WBMEM:  begin rw = 1; m2r = 2'b01; end
            MWRITE: begin mwr = 1; iord = 1; end
            EXR:    begin alua = 1; aop = 2'b10; end
            EXI:    begin alua = 1; alub = 2'b11; aop = 2'b10; end
            WBALU:  rw = 1;
            BR:     begin alua = 1; aop = 2'b01; pcwc = 1; pcs = 1; end
            JAL:    begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 1; end
            TRAP:   trp = 1;
            default: ;
        endcase
        return {pcw, pcwc, pcs, iord, irw, mrd, mwr, m2r, aop, alua, alub, rw, trp, cause, st};
    endfunction

    task automatic add(input logic [3:0] st, input logic mr, input logic [6:0] op, input int n);
        for (int i = 0; i < n; i++) plan.push_back('{st: st, mr: mr, op: op});
    endtask

    // Advances one cycle, drives the step's inputs, queues its expectation, stops at the sample point.
    task automatic drive_step(input step_t s, input string tag);
        @(posedge clk);
        #1;
        mem_ready = s.mr;
        opcode    = s.op;
        sb.push_back('{v: exp_vec(s.st, s.mr, (s.st == TRAP) ? exp_cause : 2'b00), tag: tag});
        @(negedge clk);
    endtask

    task automatic test_reset(input string name);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_R;
        #1;
        checks++;
        if (obs !== exp_vec(IDLE, 1'b1, 2'b00)) begin
            errors++;
            $display("FAIL %s_held: got %h expected %h", name, obs, exp_vec(IDLE, 1'b1, 2'b00));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cause = 2'b00;
        @(negedge clk);
        checks++;
        if (obs !== exp_vec(IDLE, 1'b1, 2'b00)) begin
            errors++;
            $display("FAIL %s_first: got %h expected %h", name, obs, exp_vec(IDLE, 1'b1, 2'b00));
        end
    endtask

    task automatic run_plan_checks(input string name);
        foreach (plan[i]) begin
            drive_step(plan[i], $sformatf("%s_%0d", name, i));
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
        plan.delete();
    endtask

    task automatic test_rtype();
        test_reset("rst_rtype");
        add(FETCH, 1, OP_R, 1); add(DECODE, 1, OP_R, 1); add(EXR, 1, OP_R, 1);
        add(WBALU, 1, OP_R, 1); add(FETCH, 1, OP_R, 1);
        run_plan_checks("rtype");
    endtask

    task automatic test_load_stall();
        test_reset("rst_load");
        add(FETCH, 1, OP_LOAD, 1); add(DECODE, 1, OP_LOAD, 1); add(MADDR, 1, OP_LOAD, 1);
        add(MREAD, 0, OP_LOAD, 3); add(MREAD, 1, OP_LOAD, 1); add(WBMEM, 1, OP_LOAD, 1);
        add(FETCH, 1, OP_LOAD, 1);
        run_plan_checks("load_stall");
    endtask

    task automatic test_timeout_fetch();
        test_reset("rst_tofetch");
        exp_cause = 2'b10;
        add(FETCH, 0, OP_R, 8); add(TRAP, 1, OP_R, 4);
        run_plan_checks("timeout_fetch");
    endtask

    task automatic test_illegal();
        test_reset("rst_illegal");
        exp_cause = 2'b01;
        add(FETCH, 1, OP_BAD, 1); add(DECODE, 1, OP_BAD, 1);
        add(TRAP, 1, OP_STORE, 2); add(TRAP, 0, OP_R, 2);
        run_plan_checks("illegal");
    endtask

    task automatic test_branch_jal();
        test_reset("rst_branch");
        add(FETCH, 1, OP_BR, 1); add(DECODE, 1, OP_BR, 1); add(BR, 1, OP_BR, 1);
        add(FETCH, 1, OP_BR, 1);
        run_plan_checks("branch");
        test_reset("rst_jal");
        add(FETCH, 1, OP_JAL, 1); add(DECODE, 1, OP_JAL, 1);
`ifdef MCU_JAL_EN
        add(JAL, 1, OP_JAL, 1); add(FETCH, 1, OP_JAL, 1);
`else
        exp_cause = 2'b01;
        add(TRAP, 1, OP_JAL, 2);
`endif
        run_plan_checks("jal");
    endtask

    // Ready arriving exactly at the last tolerated count must be accepted in both FETCH and MEM_READ.
    task automatic test_wait_boundary();
        test_reset("rst_boundary");
        add(FETCH, 0, OP_LOAD, 7); add(FETCH, 1, OP_LOAD, 1); add(DECODE, 1, OP_LOAD, 1);
        add(MADDR, 1, OP_LOAD, 1); add(MREAD, 0, OP_LOAD, 7); add(MREAD, 1, OP_LOAD, 1);
        add(WBMEM, 1, OP_LOAD, 1); add(FETCH, 1, OP_LOAD, 1);
        run_plan_checks("boundary");
    endtask

    task automatic test_write_timeout();
        test_reset("rst_wtimeout");
        exp_cause = 2'b10;
        add(FETCH, 1, OP_STORE, 1); add(DECODE, 1, OP_STORE, 1); add(MADDR, 1, OP_STORE, 1);
        add(MWRITE, 0, OP_STORE, 8); add(TRAP, 1, OP_BAD, 2);
        run_plan_checks("write_timeout");
    endtask

    task automatic test_reset_mid_write();
        test_reset("rst_midwrite");
        add(FETCH, 1, OP_STORE, 1); add(DECODE, 1, OP_STORE, 1); add(MADDR, 1, OP_STORE, 1);
        add(MWRITE, 0, OP_STORE, 2);
        run_plan_checks("mid_write");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== exp_vec(IDLE, 1'b0, 2'b00)) begin
            errors++;
            $display("FAIL mid_write_abort: got %h expected %h", obs, exp_vec(IDLE, 1'b0, 2'b00));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_reset("rst_b2b");
        add(FETCH, 1, OP_I, 1); add(DECODE, 1, OP_I, 1); add(EXI, 1, OP_I, 1); add(WBALU, 1, OP_I, 1);
        add(FETCH, 0, OP_STORE, 2); add(FETCH, 1, OP_STORE, 1); add(DECODE, 1, OP_STORE, 1);
        add(MADDR, 1, OP_STORE, 1); add(MWRITE, 1, OP_STORE, 1);
        add(FETCH, 1, OP_R, 1); add(DECODE, 1, OP_R, 1); add(EXR, 1, OP_R, 1); add(WBALU, 1, OP_R, 1);
        add(FETCH, 1, OP_BR, 1); add(DECODE, 1, OP_BR, 1); add(BR, 1, OP_BR, 1); add(FETCH, 1, OP_BR, 1);
        run_plan_checks("b2b");
    endtask

    initial begin
        test_reset("reset");
        test_rtype();
        test_load_stall();
        test_timeout_fetch();
        test_illegal();
        test_branch_jal();
        test_wait_boundary();
        test_write_timeout();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
